// File: rtl/peri_bus_arbiter.sv
// -----------------------------------------------------------------------------
// peri_bus_arbiter
//
// Shares the single peripheral bus (LED, switch, seg registers) between two
// masters: M0 = CPU load/store path, M1 = debug/loader port.
//
// Each granted request is registered onto the bus for exactly one cycle (XFER).
// The read data is captured at the end of that cycle, and the owner gets a
// one-cycle registered ack in the following cycle (RESP). Requests outside the
// peripheral window are acked with err=1 and never strobe the bus.
//
// Timing: a request seen in IDLE at cycle N strobes the bus in cycle N+1 and
// is acked in cycle N+2. A waiting request from the other master is granted
// on the ack cycle, so back-to-back accesses run at one per two cycles.
//
// Configuration macro:
//   PBUS_FIXED_PRIO_EN  defined   : fixed priority, M0 wins whenever both
//                                   masters request (M1 may starve).
//                       undefined : round-robin through the last-grant pointer.
//
// Ports:
//   clk_to_arb, rst_n_to_arb        clock (posedge) / async active-low reset
//   mX_req, mX_we, mX_addr,         master request, held stable until own ack
//   mX_wdata
//   mX_ack, mX_err, mX_rdata        registered completion: one-cycle ack,
//                                   err = address outside window, read data
//   pbus_addr, pbus_wdata           peripheral address / write data (held)
//   pbus_we, pbus_re                one-cycle write / read strobes
//   pbus_rdata                      peripheral read data, combinational
//                                   from pbus_addr
// -----------------------------------------------------------------------------
module peri_bus_arbiter #(
    parameter logic [31:0] PERI_BASE = 32'hFFFF_F000,
    parameter logic [31:0] PERI_MASK = 32'hFFFF_F000
) (
    input  logic        clk_to_arb,
    input  logic        rst_n_to_arb,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,

    output logic [31:0] pbus_addr,
    output logic        pbus_we,
    output logic        pbus_re,
    output logic [31:0] pbus_wdata,
    input  logic [31:0] pbus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;        // 0 = M0, 1 = M1
    logic        we_q, we_d;              // latched direction of the owner
    logic        hit_q, hit_d;            // latched window match of the owner
`ifndef PBUS_FIXED_PRIO_EN
    logic        last_q, last_d;          // master granted most recently
`endif
    logic [31:0] pbus_addr_q, pbus_addr_d;
    logic [31:0] pbus_wdata_q, pbus_wdata_d;
    logic        pbus_we_q, pbus_we_d;
    logic        pbus_re_q, pbus_re_d;
    logic        m0_ack_q, m0_ack_d;
    logic        m0_err_q, m0_err_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic        m1_ack_q, m1_ack_d;
    logic        m1_err_q, m1_err_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;

    // Arbitration intermediates
    logic        cand0, cand1;            // requests eligible this cycle
    logic        grant1;                  // 1 = grant M1, 0 = grant M0
    logic        sel_we;
    logic        sel_hit;
    logic [31:0] sel_addr, sel_wdata;
    logic [31:0] xfer_rdata;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        hit_d        = hit_q;
`ifndef PBUS_FIXED_PRIO_EN
        last_d       = last_q;
`endif
        pbus_addr_d  = pbus_addr_q;       // address/data hold between strobes
        pbus_wdata_d = pbus_wdata_q;
        pbus_we_d    = 1'b0;              // strobes are single-cycle pulses
        pbus_re_d    = 1'b0;
        m0_ack_d     = 1'b0;
        m0_err_d     = 1'b0;
        m0_rdata_d   = '0;
        m1_ack_d     = 1'b0;
        m1_err_d     = 1'b0;
        m1_rdata_d   = '0;
        cand0        = 1'b0;
        cand1        = 1'b0;
        xfer_rdata   = '0;

        // In RESP the owner still holds the request it is being acked for,
        // so that request must not be granted a second time.
        case (state_q)
            IDLE: begin
                cand0 = m0_req;
                cand1 = m1_req;
            end
            RESP: begin
                cand0 = m0_req && owner_q;
                cand1 = m1_req && !owner_q;
`ifdef PBUS_FIXED_PRIO_EN
                // After an M0 access go back through IDLE so that an M0
                // re-request still beats a waiting M1.
                if (!owner_q) cand1 = 1'b0;
`endif
            end
            default: ;
        endcase

`ifdef PBUS_FIXED_PRIO_EN
        grant1 = cand1 && !cand0;
`else
        // When both masters request, grant the one that did not go last.
        grant1 = cand1 && (!cand0 || !last_q);
`endif

        sel_we    = grant1 ? m1_we    : m0_we;
        sel_addr  = grant1 ? m1_addr  : m0_addr;
        sel_wdata = grant1 ? m1_wdata : m0_wdata;
        sel_hit   = (sel_addr & PERI_MASK) == PERI_BASE;

        case (state_q)
            IDLE, RESP: begin
                if (cand0 || cand1) begin
                    state_d = XFER;
                    owner_d = grant1;
                    we_d    = sel_we;
                    hit_d   = sel_hit;
`ifndef PBUS_FIXED_PRIO_EN
                    last_d  = grant1;
`endif
                    // Out-of-window requests never touch the bus.
                    if (sel_hit) begin
                        pbus_addr_d  = sel_addr;
                        pbus_wdata_d = sel_wdata;
                        pbus_we_d    = sel_we;
                        pbus_re_d    = !sel_we;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            XFER: begin
                state_d    = RESP;
                xfer_rdata = (hit_q && !we_q) ? pbus_rdata : 32'h0;
                if (owner_q) begin
                    m1_ack_d   = 1'b1;
                    m1_err_d   = !hit_q;
                    m1_rdata_d = xfer_rdata;
                end else begin
                    m0_ack_d   = 1'b1;
                    m0_err_d   = !hit_q;
                    m0_rdata_d = xfer_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_to_arb or negedge rst_n_to_arb) begin
        if (!rst_n_to_arb) begin
            // A reset mid-transaction drops the strobes at once and clears the
            // pending ack, so the aborted access is never completed.
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            hit_q        <= 1'b0;
`ifndef PBUS_FIXED_PRIO_EN
            last_q       <= 1'b1;         // M0 wins the first contested grant
`endif
            pbus_addr_q  <= '0;
            pbus_wdata_q <= '0;
            pbus_we_q    <= 1'b0;
            pbus_re_q    <= 1'b0;
            m0_ack_q     <= 1'b0;
            m0_err_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_ack_q     <= 1'b0;
            m1_err_q     <= 1'b0;
            m1_rdata_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the values
            // from before the edge, independent of statement order.
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            hit_q        <= hit_d;
`ifndef PBUS_FIXED_PRIO_EN
            last_q       <= last_d;
`endif
            pbus_addr_q  <= pbus_addr_d;
            pbus_wdata_q <= pbus_wdata_d;
            pbus_we_q    <= pbus_we_d;
            pbus_re_q    <= pbus_re_d;
            m0_ack_q     <= m0_ack_d;
            m0_err_q     <= m0_err_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_ack_q     <= m1_ack_d;
            m1_err_q     <= m1_err_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign pbus_addr  = pbus_addr_q;
    assign pbus_wdata = pbus_wdata_q;
    assign pbus_we    = pbus_we_q;
    assign pbus_re    = pbus_re_q;
    assign m0_ack     = m0_ack_q;
    assign m0_err     = m0_err_q;
    assign m0_rdata   = m0_rdata_q;
    assign m1_ack     = m1_ack_q;
    assign m1_err     = m1_err_q;
    assign m1_rdata   = m1_rdata_q;

endmodule
